// File: rtl/sseg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sseg_pkg                                                                   |
// | Shared types and constants for the seven-segment scan driver.              |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package sseg_pkg;

    typedef logic [1:0] digit_idx_t;
    typedef logic [3:0] nibble_t;

    localparam logic [3:0] AN_ALL_OFF = 4'hF;
    localparam int         NUM_DIGITS = 4;

    // Index of the most-significant nonzero nibble; 0 when the word is zero.
    function automatic digit_idx_t msd_index(input logic [15:0] word);
        digit_idx_t idx;
        idx = '0;
        for (int k = 1; k < NUM_DIGITS; k++) begin
            if (word[4*k +: 4] != 4'h0) begin
                idx = digit_idx_t'(k);
            end
        end
        return idx;
    endfunction

endpackage : sseg_pkg
`default_nettype wire

// File: rtl/sseg_refresh_tick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sseg_refresh_tick                                                          |
// | Free-running prescaler: one-cycle tick every CLK_HZ/REFRESH_HZ cycles.     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module sseg_refresh_tick #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int REFRESH_HZ = 1000
) (
    input  logic clk,
    input  logic reset,
    output logic tick_o
);

    localparam int DIV   = CLK_HZ / REFRESH_HZ;
    localparam int CNT_W = (DIV >= 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(DIV - 1);

    generate
        if (DIV < 2) begin : g_div_check
            $error("sseg_refresh_tick: CLK_HZ/REFRESH_HZ must be at least 2");
        end
    endgenerate

    logic [CNT_W-1:0] tick_cnt_q;
    logic [CNT_W-1:0] tick_cnt_d;

    assign tick_o = (tick_cnt_q == TERMINAL);

    always_comb begin
        tick_cnt_d = tick_cnt_q + CNT_W'(1);
        if (tick_o) begin
            tick_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

endmodule : sseg_refresh_tick
`default_nettype wire

// File: rtl/sseg_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sseg_scan_driver                                                           |
// | 4-digit multiplexed scanner with frame-aligned double-buffered display     |
// | word. Optional leading-zero blanking: define LEADING_ZERO_BLANK_EN.        |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int REFRESH_HZ = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] value_in,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  digit_en,
    output logic [3:0]  binary,
    output logic [3:0]  an,
    output logic        dp_n,
    output logic        frame_done,
    output logic        busy
);

    logic       tick;
    logic       boundary;
    logic       blank;
    logic       digit_off;

    digit_idx_t digit_q,         digit_d;
    logic [15:0] shadow_q,       shadow_d;
    logic [3:0]  shadow_dp_q,    shadow_dp_d;
    logic [15:0] pending_q,      pending_d;
    logic [3:0]  pending_dp_q,   pending_dp_d;
    logic        pending_valid_q, pending_valid_d;

    nibble_t     binary_q,       binary_d;
    logic [3:0]  an_q,           an_d;
    logic        dp_n_q,         dp_n_d;
    logic        frame_done_q;
    logic        busy_q;

    sseg_refresh_tick #(
        .CLK_HZ     (CLK_HZ),
        .REFRESH_HZ (REFRESH_HZ)
    ) u_refresh_tick (
        .clk    (clk),
        .reset  (reset),
        .tick_o (tick)
    );

    assign boundary = tick && (digit_q == digit_idx_t'(NUM_DIGITS - 1));

`ifdef LEADING_ZERO_BLANK_EN
    // Decided from shadow, so the blank pattern is stable across a frame.
    assign blank = (digit_q > msd_index(shadow_q));
`else
    assign blank = 1'b0;
`endif

    assign digit_off = ~digit_en[digit_q] | blank;

    // Scan position and double-buffer bookkeeping.
    always_comb begin
        digit_d         = digit_q;
        shadow_d        = shadow_q;
        shadow_dp_d     = shadow_dp_q;
        pending_d       = pending_q;
        pending_dp_d    = pending_dp_q;
        pending_valid_d = pending_valid_q;

        if (tick) begin
            digit_d = digit_q + digit_idx_t'(1);
        end

        if (load) begin
            pending_d       = value_in;
            pending_dp_d    = dp_in;
            pending_valid_d = 1'b1;
        end

        // A load coincident with the boundary bypasses pending entirely.
        if (boundary) begin
            if (load) begin
                shadow_d    = value_in;
                shadow_dp_d = dp_in;
            end else if (pending_valid_q) begin
                shadow_d    = pending_q;
                shadow_dp_d = pending_dp_q;
            end
            pending_valid_d = 1'b0;
        end
    end

    always_comb begin
        binary_d = shadow_q[{digit_q, 2'b00} +: 4];
        an_d     = digit_off ? AN_ALL_OFF : ~(4'b0001 << digit_q);
        dp_n_d   = digit_off | ~shadow_dp_q[digit_q];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit_q         <= '0;
            shadow_q        <= '0;
            shadow_dp_q     <= '0;
            pending_q       <= '0;
            pending_dp_q    <= '0;
            pending_valid_q <= 1'b0;
            binary_q        <= '0;
            an_q            <= AN_ALL_OFF;
            dp_n_q          <= 1'b1;
            frame_done_q    <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            digit_q         <= digit_d;
            shadow_q        <= shadow_d;
            shadow_dp_q     <= shadow_dp_d;
            pending_q       <= pending_d;
            pending_dp_q    <= pending_dp_d;
            pending_valid_q <= pending_valid_d;
            binary_q        <= binary_d;
            an_q            <= an_d;
            dp_n_q          <= dp_n_d;
            frame_done_q    <= boundary;
            busy_q          <= pending_valid_d;
        end
    end

    assign binary     = binary_q;
    assign an         = an_q;
    assign dp_n       = dp_n_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule : sseg_scan_driver
`default_nettype wire
